// File: rtl/cpu_datapath.sv
// cpu_datapath: IR/PC/accumulator/register-file/ALU datapath steered by the controller FSM
// Inputs : CLK, CLB (sync active-high reset), LoadIR, IncPC, SelPC, LoadPC, LoadReg,
//          LoadAcc, SelAcc[1:0], SelALU[3:0], Instr[ADDR_W+3:0]
// Outputs: PCAddr[ADDR_W-1:0], Opcode[3:0], Z, C (combinational ALU flags), AccOut[DATA_W-1:0]
module cpu_datapath #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              CLK,
    input  logic              CLB,
    input  logic              LoadIR,
    input  logic              IncPC,
    input  logic              SelPC,
    input  logic              LoadPC,
    input  logic              LoadReg,
    input  logic              LoadAcc,
    input  logic [1:0]        SelAcc,
    input  logic [3:0]        SelALU,
    input  logic [ADDR_W+3:0] Instr,
    output logic [ADDR_W-1:0] PCAddr,
    output logic [3:0]        Opcode,
    output logic              Z,
    output logic              C,
    output logic [DATA_W-1:0] AccOut
);
    localparam int NREG = 2 ** ADDR_W;
    logic [ADDR_W-1:0] pc_q, pc_d, idx;
    logic [ADDR_W+3:0] ir_q, ir_d;
    logic [DATA_W-1:0] acc_q, acc_d, rb, alu_r;
    logic [DATA_W-1:0] rf_q [NREG];
    logic [DATA_W:0]   sum, diff;
    logic              alu_c;
    // register index and immediate share the low IR field
    assign idx    = ir_q[ADDR_W-1:0];
    assign rb     = rf_q[idx];
    assign sum    = {1'b0, acc_q} + {1'b0, rb};
    // top bit of the widened difference is the unsigned borrow
    assign diff   = {1'b0, acc_q} - {1'b0, rb};
    always_comb begin
        alu_r = acc_q;
        alu_c = 1'b0;
        case (SelALU)
            4'b0001: {alu_c, alu_r} = sum;
            4'b0010: {alu_c, alu_r} = diff;
            4'b0011: alu_r = ~(acc_q | rb);
            4'b1011: {alu_c, alu_r} = {acc_q, 1'b0};
            4'b1100: {alu_r, alu_c} = {1'b0, acc_q};
            default: ;
        endcase
    end
    assign pc_d  = LoadPC ? (SelPC ? rb[ADDR_W-1:0] : idx) : IncPC ? pc_q + ADDR_W'(1) : pc_q;
    assign ir_d  = LoadIR ? Instr : ir_q;
    assign acc_d = !LoadAcc         ? acc_q :
                   SelAcc == 2'b00  ? alu_r :
                   SelAcc == 2'b10  ? rb    :
                   SelAcc == 2'b11  ? DATA_W'(idx) : acc_q;
    always_ff @(posedge CLK) begin
        if (CLB) begin
            pc_q  <= '0;
            ir_q  <= '0;
            acc_q <= '0;
            for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
        end else begin
            pc_q  <= pc_d;
            ir_q  <= ir_d;
            acc_q <= acc_d;
            if (LoadReg) rf_q[idx] <= acc_q;
        end
    end
    assign PCAddr = pc_q;
    assign Opcode = ir_q[ADDR_W+3:ADDR_W];
    assign Z      = (alu_r == '0);
    assign C      = alu_c;
    assign AccOut = acc_q;
endmodule

// File: tb/tb_cpu_datapath.sv
// tb_cpu_datapath: table-driven ALU vectors plus hand sequences, checked through an expectation queue
module tb_cpu_datapath;
    logic       CLK = 1'b0;
    logic       CLB, LoadIR, IncPC, SelPC, LoadPC, LoadReg, LoadAcc;
    logic [1:0] SelAcc;
    logic [3:0] SelALU;
    logic [7:0] Instr;
    logic [3:0] PCAddr, Opcode;
    logic       Z, C;
    logic [7:0] AccOut;

    cpu_datapath dut (
        .CLK(CLK), .CLB(CLB), .LoadIR(LoadIR), .IncPC(IncPC), .SelPC(SelPC),
        .LoadPC(LoadPC), .LoadReg(LoadReg), .LoadAcc(LoadAcc), .SelAcc(SelAcc),
        .SelALU(SelALU), .Instr(Instr), .PCAddr(PCAddr), .Opcode(Opcode),
        .Z(Z), .C(C), .AccOut(AccOut)
    );

    always #5 CLK = ~CLK;

    typedef enum int {K_PC, K_OP, K_Z, K_C, K_ACC} kind_t;
    typedef struct {
        string      name;
        kind_t      kind;
        logic [7:0] exp;
    } exp_t;
    typedef struct {
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        logic       c;
        logic       z;
    } vec_t;

    exp_t sb[$];
    int   checks = 0;
    int   passed = 0;

    function automatic void push_exp(string n, kind_t k, logic [7:0] e);
        sb.push_back('{n, k, e});
    endfunction

    function automatic logic [7:0] observe(kind_t k);
        case (k)
            K_PC:    return {4'h0, PCAddr};
            K_OP:    return {4'h0, Opcode};
            K_Z:     return {7'h0, Z};
            K_C:     return {7'h0, C};
            default: return AccOut;
        endcase
    endfunction

    task automatic drain();
        exp_t       e;
        logic [7:0] a;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            a = observe(e.kind);
            checks++;
            if (a === e.exp) passed++;
            else $display("FAIL %s: got %h want %h", e.name, a, e.exp);
        end
    endtask

    task automatic idle();
        CLB = 0; LoadIR = 0; IncPC = 0; SelPC = 0; LoadPC = 0;
        LoadReg = 0; LoadAcc = 0; SelAcc = 2'b01; SelALU = 4'h0; Instr = 8'h00;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
        idle();
    endtask

    task automatic load_ir(input logic [7:0] v);
        Instr = v; LoadIR = 1; tick();
    endtask

    task automatic acc_imm(input logic [3:0] v);
        load_ir({4'hD, v});
        LoadAcc = 1; SelAcc = 2'b11; tick();
    endtask

    task automatic alu_acc(input logic [3:0] op);
        SelALU = op; LoadAcc = 1; SelAcc = 2'b00; tick();
    endtask

    task automatic store(input logic [3:0] r);
        load_ir({4'h5, r});
        LoadReg = 1; tick();
    endtask

    // builds any byte from two nibbles; R15 is used as scratch
    task automatic set_acc(input logic [7:0] v);
        acc_imm(v[3:0]);
        store(4'hF);
        acc_imm(v[7:4]);
        repeat (4) alu_acc(4'hB);
        load_ir(8'h0F);
        alu_acc(4'h1);
    endtask

    task automatic set_reg(input logic [3:0] r, input logic [7:0] v);
        set_acc(v);
        store(r);
    endtask

    vec_t vecs[10];

    initial begin
        vecs[0] = '{4'b0001, 8'hF0, 8'h20, 8'h10, 1'b1, 1'b0};
        vecs[1] = '{4'b0010, 8'h33, 8'h33, 8'h00, 1'b0, 1'b1};
        vecs[2] = '{4'b0010, 8'h01, 8'h02, 8'hFF, 1'b1, 1'b0};
        vecs[3] = '{4'b1011, 8'h81, 8'h00, 8'h02, 1'b1, 1'b0};
        vecs[4] = '{4'b1100, 8'h81, 8'h00, 8'h40, 1'b1, 1'b0};
        vecs[5] = '{4'b0011, 8'hF0, 8'h0F, 8'h00, 1'b0, 1'b1};
        vecs[6] = '{4'b0000, 8'h5A, 8'hFF, 8'h5A, 1'b0, 1'b0};
        vecs[7] = '{4'b1111, 8'h00, 8'h77, 8'h00, 1'b0, 1'b1};
        vecs[8] = '{4'b0001, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0};
        vecs[9] = '{4'b0011, 8'h00, 8'h00, 8'hFF, 1'b0, 1'b0};

        idle();
        CLB = 1; LoadIR = 1; IncPC = 1; LoadPC = 1; LoadReg = 1; LoadAcc = 1;
        SelAcc = 2'b11; Instr = 8'hD5;
        repeat (2) @(posedge CLK);
        #1;
        idle();
        push_exp("rst_pc", K_PC, 8'h00);
        push_exp("rst_op", K_OP, 8'h00);
        push_exp("rst_acc", K_ACC, 8'h00);
        push_exp("rst_z", K_Z, 8'h01);
        push_exp("rst_c", K_C, 8'h00);
        drain();

        Instr = 8'hD7; LoadIR = 1; tick();
        push_exp("ldi_op", K_OP, 8'h0D);
        push_exp("ldi_pc_hold", K_PC, 8'h00);
        drain();
        SelAcc = 2'b11; LoadAcc = 1; IncPC = 1; tick();
        push_exp("ldi_acc", K_ACC, 8'h07);
        push_exp("ldi_pc", K_PC, 8'h01);
        drain();
        store(4'h3);
        acc_imm(4'h0);
        load_ir(8'hA3);
        LoadAcc = 1; SelAcc = 2'b10; tick();
        push_exp("st_r3", K_ACC, 8'h07);
        drain();

        acc_imm(4'h5);
        load_ir(8'h03);
        LoadReg = 1; LoadAcc = 1; SelAcc = 2'b10; tick();
        push_exp("swap_acc", K_ACC, 8'h07);
        drain();
        LoadAcc = 1; SelAcc = 2'b10; tick();
        push_exp("swap_reg", K_ACC, 8'h05);
        drain();
        LoadAcc = 1; SelAcc = 2'b01; tick();
        push_exp("acc_hold", K_ACC, 8'h05);
        drain();

        for (int i = 0; i < 10; i++) begin
            set_reg(4'h2, vecs[i].b);
            set_acc(vecs[i].a);
            load_ir(8'h02);
            SelALU = vecs[i].op;
            #1;
            push_exp($sformatf("alu%0d_c", i), K_C, {7'h0, vecs[i].c});
            push_exp($sformatf("alu%0d_z", i), K_Z, {7'h0, vecs[i].z});
            drain();
            LoadAcc = 1; SelAcc = 2'b00; tick();
            push_exp($sformatf("alu%0d_res", i), K_ACC, vecs[i].res);
            drain();
        end

        load_ir(8'h7F);
        LoadPC = 1; tick();
        push_exp("pc_ld_f", K_PC, 8'h0F);
        drain();
        IncPC = 1; tick();
        push_exp("pc_wrap", K_PC, 8'h00);
        drain();
        load_ir(8'h79);
        LoadPC = 1; SelPC = 0; IncPC = 1; tick();
        push_exp("pc_ld_wins", K_PC, 8'h09);
        drain();
        set_reg(4'h4, 8'h0C);
        load_ir(8'h64);
        LoadPC = 1; SelPC = 1; tick();
        push_exp("pc_reg", K_PC, 8'h0C);
        drain();
        load_ir(8'h79);
        Instr = 8'h72; LoadIR = 1; LoadPC = 1; SelPC = 0; tick();
        push_exp("ir_old_imm", K_PC, 8'h09);
        push_exp("ir_new_op", K_OP, 8'h07);
        drain();

        acc_imm(4'h9);
        CLB = 1; LoadPC = 1; IncPC = 1; Instr = 8'hBA; LoadIR = 1;
        LoadAcc = 1; SelAcc = 2'b11; tick();
        push_exp("mid_rst_pc", K_PC, 8'h00);
        push_exp("mid_rst_op", K_OP, 8'h00);
        push_exp("mid_rst_acc", K_ACC, 8'h00);
        drain();
        IncPC = 1; tick();
        push_exp("post_rst_inc", K_PC, 8'h01);
        drain();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
